disp_pattern_sched: RTL and testbench



---
 rtl/disp_pkg.sv | 36 +++
 rtl/vsync_boundary_det.sv | 54 +++++
 rtl/disp_pattern_sched.sv | 175 +++++++++++++++++
 tb/tb_disp_pattern_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Purpose  : Shared definitions for the display test-pattern scheduler:
//            command op codes, scheduler FSM state encoding, 1080p60 frame
//            constants and a modulo pattern-increment helper.
// Revision : 1.0 - initial release
// ============================================================================
package disp_pkg;

  // Command op codes carried on cmd_op
  localparam logic [1:0] CMD_STOP = 2'd0;
  localparam logic [1:0] CMD_RUN  = 2'd1;
  localparam logic [1:0] CMD_SET  = 2'd2;
  localparam logic [1:0] CMD_STEP = 2'd3;

  // Scheduler FSM states (explicit 2-bit encoding)
  typedef enum logic [1:0] {
    ST_AUTO = 2'd0,
    ST_HOLD = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  // 1080p60 raster totals; the default watchdog spans two full frames
  localparam int H_TOTAL         = 2200;
  localparam int V_TOTAL         = 1125;
  localparam int FRAME_CYC       = H_TOTAL * V_TOTAL;
  localparam int TIMEOUT_DEFAULT = 2 * FRAME_CYC;

  // Next pattern index, wrapping from n-1 back to 0
  function automatic logic [2:0] pat_inc(input logic [2:0] p, input logic [3:0] n);
    return ({1'b0, p} == (n - 4'd1)) ? 3'd0 : (p + 3'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vsync_boundary_det.sv
`default_nettype none
// ============================================================================
// Module   : vsync_boundary_det
// Purpose  : Detects the vsync rising edge (frame boundary) and runs the
//            lost-timing watchdog.
// Ports    : clk, rst_n   - clock, async active-low reset
//            vsync_i      - active-high vsync, synchronous to clk
//            boundary     - high in the cycle where vsync_i rises
//            timeout      - high while the watchdog is saturated at
//                           TIMEOUT_CYC-1 (no boundary for that long)
// Revision : 1.0 - initial release
// ============================================================================
module vsync_boundary_det #(
  parameter int TIMEOUT_CYC = 4950000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic boundary,
  output logic timeout
);

  localparam int              WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  logic            vsync_d_q, vsync_d_d;
  logic [WD_W-1:0] wd_q, wd_d;

  assign boundary = vsync_i & ~vsync_d_q;
  assign timeout  = (wd_q == WD_MAX);

  always_comb begin
    vsync_d_d = vsync_i;
    wd_d      = wd_q;
    if (boundary) begin
      wd_d = '0;
    end else if (!timeout) begin
      wd_d = wd_q + 1'b1;
    end
    // otherwise saturate so timeout stays asserted until the next boundary
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      vsync_d_q <= vsync_d_d;
      wd_q      <= wd_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/disp_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module   : disp_pattern_sched
// Purpose  : Frame-synchronous test-pattern scheduler. Auto-cycles patterns
//            every FRAME_DWELL frames, or holds/steps/sets them via a
//            valid/ready command port. Changes land only on vsync
//            boundaries (or immediately once timing is lost).
// Ports    : clk, rst_n            - clock, async active-low reset
//            vsync_i               - vsync from the timing generator
//            cmd_valid/cmd_ready   - command handshake
//            cmd_op, cmd_pat       - op code and SET target
//            pat_sel               - current pattern to the datapath
//            pat_update            - pulse after pat_sel re-evaluation
//            cmd_err               - pulse when a SET is rejected
//            auto_o                - scheduler is auto-cycling
//            timing_lost           - watchdog expired, cleared at boundary
//            frame_cnt             - free-running boundary count
// Revision : 1.0 - initial release
// ============================================================================
module disp_pattern_sched
  import disp_pkg::*;
#(
  parameter int NUM_PATTERNS = 8,
  parameter int FRAME_DWELL  = 60,
  parameter int TIMEOUT_CYC  = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_pat,
  output logic [2:0]  pat_sel,
  output logic        pat_update,
  output logic        cmd_err,
  output logic        auto_o,
  output logic        timing_lost,
  output logic [15:0] frame_cnt
);

  localparam logic [3:0]  NP_W      = 4'(NUM_PATTERNS);
  localparam logic [15:0] DWELL_MAX = 16'(FRAME_DWELL - 1);

  logic        boundary, timeout;

  state_e      state_q, state_d;
  logic [2:0]  pat_q, pat_d;
  logic [15:0] dwell_q, dwell_d;
  logic [15:0] frame_q, frame_d;
  logic [1:0]  pend_op_q, pend_op_d;
  logic [2:0]  pend_pat_q, pend_pat_d;
  logic        pre_auto_q, pre_auto_d;
  logic        pat_update_q, pat_update_d;
  logic        cmd_err_q, cmd_err_d;
  logic        lost_q, lost_d;
  logic        init_q;

  logic        counting, accept, apply;

  vsync_boundary_det #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync_i  (vsync_i),
    .boundary (boundary),
    .timeout  (timeout)
  );

  // init_q keeps cmd_ready low through reset and up to the first live edge
  assign cmd_ready = init_q & (state_q != ST_PEND);
  assign accept    = cmd_valid & cmd_ready;
  // Dwell keeps running while a command waits, if we came from AUTO
  assign counting  = (state_q == ST_AUTO) | ((state_q == ST_PEND) & pre_auto_q);
  // timeout stays high while saturated, so once timing is lost a pending
  // command is applied on the cycle after it was accepted
  assign apply     = (state_q == ST_PEND) & (boundary | timeout);

  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    dwell_d      = dwell_q;
    frame_d      = frame_q;
    pend_op_d    = pend_op_q;
    pend_pat_d   = pend_pat_q;
    pre_auto_d   = pre_auto_q;
    pat_update_d = 1'b0;
    cmd_err_d    = 1'b0;
    lost_d       = lost_q;

    if (boundary) begin
      frame_d      = frame_q + 16'd1;
      pat_update_d = 1'b1;
      lost_d       = 1'b0;
      if (counting) begin
        if (dwell_q == DWELL_MAX) begin
          dwell_d = 16'd0;
          // in PEND the applied command decides pat_sel instead
          if (state_q == ST_AUTO) pat_d = pat_inc(pat_q, NP_W);
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end
    end else if (timeout) begin
      lost_d = 1'b1;
    end

    if (apply) begin
      pat_update_d = 1'b1;
      case (pend_op_q)
        CMD_STOP: state_d = ST_HOLD;
        CMD_RUN: begin
          dwell_d = 16'd0;
          state_d = ST_AUTO;
        end
        CMD_SET: begin
          if ({1'b0, pend_pat_q} < NP_W) begin
            pat_d   = pend_pat_q;
            state_d = ST_HOLD;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = pre_auto_q ? ST_AUTO : ST_HOLD;
          end
        end
        default: begin
          pat_d   = pat_inc(pat_q, NP_W);
          state_d = ST_HOLD;
        end
      endcase
    end else if (accept) begin
      state_d    = ST_PEND;
      pend_op_d  = cmd_op;
      pend_pat_d = cmd_pat;
      pre_auto_d = (state_q == ST_AUTO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_AUTO;
      pat_q        <= 3'd0;
      dwell_q      <= 16'd0;
      frame_q      <= 16'd0;
      pend_op_q    <= CMD_STOP;
      pend_pat_q   <= 3'd0;
      pre_auto_q   <= 1'b0;
      pat_update_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      lost_q       <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      dwell_q      <= dwell_d;
      frame_q      <= frame_d;
      pend_op_q    <= pend_op_d;
      pend_pat_q   <= pend_pat_d;
      pre_auto_q   <= pre_auto_d;
      pat_update_q <= pat_update_d;
      cmd_err_q    <= cmd_err_d;
      lost_q       <= lost_d;
      init_q       <= 1'b1;
    end
  end

  assign pat_sel     = pat_q;
  assign pat_update  = pat_update_q;
  assign cmd_err     = cmd_err_q;
  assign auto_o      = counting;
  assign timing_lost = lost_q;
  assign frame_cnt   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_pattern_sched
// Purpose  : Self-checking bench for disp_pattern_sched with a reference
//            model feeding an expected-result queue; entries are popped and
//            compared whenever the DUT pulses pat_update.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_pattern_sched;

  localparam int NP = 4;
  localparam int DW = 2;
  localparam int TO = 1000;

  localparam logic [1:0] OP_STOP = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_SET  = 2'd2;
  localparam logic [1:0] OP_STEP = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync_i = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [2:0]  cmd_pat = 3'd0;
  logic [2:0]  pat_sel;
  logic        pat_update;
  logic        cmd_err;
  logic        auto_o;
  logic        timing_lost;
  logic [15:0] frame_cnt;

  disp_pattern_sched #(
    .NUM_PATTERNS (NP),
    .FRAME_DWELL  (DW),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync_i     (vsync_i),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_pat     (cmd_pat),
    .pat_sel     (pat_sel),
    .pat_update  (pat_update),
    .cmd_err     (cmd_err),
    .auto_o      (auto_o),
    .timing_lost (timing_lost),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int b_cyc = 0;
  int upd_cnt = 0;
  int err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int pat;
    int frame;
    bit au;
    bit err;
  } exp_t;

  exp_t sb[$];

  int m_pat, m_dwell, m_frame, m_op, m_arg;
  bit m_auto, m_pend, m_pre_auto;

  function automatic void model_reset();
    m_pat = 0; m_dwell = 0; m_frame = 0; m_auto = 1'b1; m_pend = 1'b0;
    m_op = 0; m_arg = 0; m_pre_auto = 1'b0;
    sb.delete();
  endfunction

  function automatic void push_exp(input bit err);
    exp_t e;
    e.pat = m_pat; e.frame = m_frame; e.au = m_auto; e.err = err;
    sb.push_back(e);
  endfunction

  function automatic bit model_apply();
    bit err = 1'b0;
    case (m_op)
      0: m_auto = 1'b0;
      1: begin m_dwell = 0; m_auto = 1'b1; end
      2: if (m_arg < NP) begin m_pat = m_arg; m_auto = 1'b0; end
         else begin err = 1'b1; m_auto = m_pre_auto; end
      default: begin m_pat = (m_pat + 1) % NP; m_auto = 1'b0; end
    endcase
    m_pend = 1'b0;
    return err;
  endfunction

  function automatic void model_boundary();
    bit err = 1'b0;
    m_frame = (m_frame + 1) % 65536;
    if (m_auto) begin
      if (m_dwell == DW - 1) begin
        m_dwell = 0;
        if (!m_pend) m_pat = (m_pat + 1) % NP;
      end else begin
        m_dwell = m_dwell + 1;
      end
    end
    if (m_pend) err = model_apply();
    push_exp(err);
  endfunction

  function automatic void model_accept(input logic [1:0] op, input logic [2:0] p);
    m_pend = 1'b1; m_op = int'(op); m_arg = int'(p); m_pre_auto = m_auto;
  endfunction

  // Monitor: every pat_update must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && pat_update) begin
      upd_cnt++;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_pat_sel", 32'(pat_sel), 32'(e.pat));
        check_eq("sb_frame_cnt", 32'(frame_cnt), 32'(e.frame));
        check_eq("sb_auto_o", 32'(auto_o), 32'(e.au));
        check_eq("sb_cmd_err", 32'(cmd_err), 32'(e.err));
      end
    end
    if (rst_n && cmd_err) err_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic vsync_pulse();
    vsync_i = 1'b1;
    model_boundary();
    @(negedge clk);
    b_cyc = cyc;
    repeat (3) @(negedge clk);
    vsync_i = 1'b0;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      vsync_pulse();
      repeat (196) @(negedge clk);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [2:0] p);
    check_eq("rdy_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_pat = p;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("rdy_in_pend", 32'(cmd_ready), 32'd0);
    model_accept(op, p);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pat_sel"}, 32'(pat_sel), 32'd0);
    check_eq({tag, "_pat_update"}, 32'(pat_update), 32'd0);
    check_eq({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
    check_eq({tag, "_auto_o"}, 32'(auto_o), 32'd1);
    check_eq({tag, "_timing_lost"}, 32'(timing_lost), 32'd0);
    check_eq({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (bad=%0d)", bad);
    $fatal(1);
  end

  int seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rdy_after_rst", 32'(cmd_ready), 32'd1);

    // 1) Auto-cycling with wrap
    for (int i = 0; i < 9; i++) begin
      check_eq("auto_seq", 32'(pat_sel), 32'(seq[i]));
      run_frames(1);
    end
    check_eq("auto_pat_end", 32'(pat_sel), 32'd0);
    check_eq("auto_frames", 32'(frame_cnt), 32'd9);
    check_eq("auto_upd_cnt", 32'(upd_cnt), 32'd9);

    // 2) SET 2 mid-frame, then hold
    send_cmd(OP_SET, 3'd2);
    repeat (50) @(negedge clk);
    check_eq("set2_rdy_wait", 32'(cmd_ready), 32'd0);
    check_eq("set2_not_yet", 32'(pat_sel), 32'd0);
    run_frames(1);
    check_eq("set2_pat", 32'(pat_sel), 32'd2);
    check_eq("set2_auto", 32'(auto_o), 32'd0);
    check_eq("set2_rdy_back", 32'(cmd_ready), 32'd1);
    run_frames(3);
    check_eq("hold_pat", 32'(pat_sel), 32'd2);

    // 3) Rejected SET, then STEP wrap from 3
    send_cmd(OP_SET, 3'd5);
    run_frames(1);
    check_eq("set5_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("set5_pat", 32'(pat_sel), 32'd2);
    send_cmd(OP_SET, 3'd3);
    run_frames(1);
    send_cmd(OP_STEP, 3'd0);
    run_frames(1);
    check_eq("step_wrap", 32'(pat_sel), 32'd0);

    // 4) Command accepted on the boundary edge
    check_eq("bnd_rdy", 32'(cmd_ready), 32'd1);
    vsync_i = 1'b1; cmd_valid = 1'b1; cmd_op = OP_SET; cmd_pat = 3'd1;
    model_boundary();
    model_accept(OP_SET, 3'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    b_cyc = cyc;
    check_eq("bnd_rdy_pend", 32'(cmd_ready), 32'd0);
    check_eq("bnd_not_applied", 32'(pat_sel), 32'd0);
    repeat (3) @(negedge clk);
    vsync_i = 1'b0;
    repeat (196) @(negedge clk);
    run_frames(1);
    check_eq("bnd_applied", 32'(pat_sel), 32'd1);

    // RUN back to auto; two frames advance once
    send_cmd(OP_RUN, 3'd0);
    run_frames(3);
    check_eq("run_auto", 32'(auto_o), 32'd1);
    check_eq("run_pat", 32'(pat_sel), 32'd2);

    // 5) Watchdog: vsync stops, STEP applied at expiry
    send_cmd(OP_STEP, 3'd0);
    void'(model_apply());
    push_exp(1'b0);
    begin
      int n = 0;
      while (!timing_lost && n < 3 * TO) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("wd_fired", 32'(timing_lost), 32'd1);
    check_eq("wd_latency", 32'(cyc - b_cyc), 32'(TO));
    check_eq("wd_step_pat", 32'(pat_sel), 32'd3);
    @(negedge clk);
    check_eq("wd_rdy", 32'(cmd_ready), 32'd1);
    send_cmd(OP_SET, 3'd2);
    void'(model_apply());
    push_exp(1'b0);
    @(negedge clk);
    check_eq("lost_fast_apply", 32'(pat_sel), 32'd2);
    check_eq("lost_still", 32'(timing_lost), 32'd1);
    run_frames(1);
    check_eq("lost_cleared", 32'(timing_lost), 32'd0);

    // 6) Reset while PEND drops the command
    send_cmd(OP_STEP, 3'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_rdy", 32'(cmd_ready), 32'd1);
    run_frames(2);
    check_eq("midrst_pat", 32'(pat_sel), 32'd1);
    check_eq("midrst_auto", 32'(auto_o), 32'd1);
    check_eq("midrst_frames", 32'(frame_cnt), 32'd2);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("total_err_pulses", 32'(err_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
